muldiv_ctrl: RTL

Iterative multiply/divide sequencer in the MIPS execute stage. Accepts MULT/MULTU/DIV/DIVU from ID/EX, runs a 32-step shift-add or restoring-divide loop, owns the architectural HI/LO registers, and stalls the front of the pipeline while the unit is busy. The ALU path is untouched; this block sits beside it and feeds MFHI/MFLO results into the EX result mux.

---
 rtl/muldiv_ctrl_pkg.sv | 36 +++
 rtl/muldiv_ctrl_iter.sv | 44 ++++
 rtl/muldiv_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation codes, FSM state encodings, step count and two's-complement helpers.
package muldiv_ctrl_pkg;

  localparam int MD_DW    = 32;
  localparam int MD_STEPS = 32;
  localparam int MD_CNT_W = $clog2(MD_STEPS);

  // The counter is loaded with MD_STEPS-1 and the last step runs when it reads 0.
  localparam logic [MD_CNT_W-1:0] MD_CNT_LOAD = MD_CNT_W'(MD_STEPS - 1);

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'b00,
    MD_OP_MULTU = 2'b01,
    MD_OP_DIV   = 2'b10,
    MD_OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ST_IDLE  = 2'b00,
    MD_ST_RUN   = 2'b01,
    MD_ST_FIXUP = 2'b10
  } md_state_e;

  function automatic logic [MD_DW-1:0] md_neg(input logic [MD_DW-1:0] x);
    return ~x + 1'b1;
  endfunction

  // abs(0x80000000) stays 0x80000000, which is the correct magnitude once
  // the value is treated as unsigned.
  function automatic logic [MD_DW-1:0] md_abs(input logic [MD_DW-1:0] x,
                                              input logic is_signed);
    return (is_signed && x[MD_DW-1]) ? md_neg(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_iter.sv
// One combinational step of the multiply/divide loop.
//   i_is_div    : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_acc_hi    : upper accumulator half (partial product / partial remainder)
//   i_acc_lo    : lower accumulator half (multiplier bits / dividend-quotient bits)
//   i_opnd      : multiplicand (MUL) or divisor (DIV), unsigned magnitude
//   o_acc_hi/lo : accumulator after this step
module muldiv_ctrl_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic             i_is_div,
  input  logic [MD_DW-1:0] i_acc_hi,
  input  logic [MD_DW-1:0] i_acc_lo,
  input  logic [MD_DW-1:0] i_opnd,
  output logic [MD_DW-1:0] o_acc_hi,
  output logic [MD_DW-1:0] o_acc_lo
);

  logic [MD_DW:0] w_sum;
  logic [MD_DW:0] w_rem;
  logic [MD_DW:0] w_diff;

  // Multiply: the 33-bit sum keeps the carry, which shifts into acc_hi[31].
  assign w_sum = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_opnd} : '0);

  // Divide: the shifted remainder needs 33 bits; a clear diff MSB means it
  // is not below the divisor.
  assign w_rem  = {i_acc_hi, i_acc_lo[MD_DW-1]};
  assign w_diff = w_rem - {1'b0, i_opnd};

  always_comb begin
    o_acc_hi = w_sum[MD_DW:1];
    o_acc_lo = {w_sum[0], i_acc_lo[MD_DW-1:1]};
    if (i_is_div) begin
      if (!w_diff[MD_DW]) begin
        o_acc_hi = w_diff[MD_DW-1:0];
        o_acc_lo = {i_acc_lo[MD_DW-2:0], 1'b1};
      end else begin
        o_acc_hi = w_rem[MD_DW-1:0];
        o_acc_lo = {i_acc_lo[MD_DW-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
// Ports:
//   clk, reset (async, active-low)
//   i_start, i_md_op, i_operand_a, i_operand_b : operation issue from ID/EX
//   i_mthi, i_mtlo, i_wdata                    : direct HI/LO writes (idle only)
//   i_hilo_read                                : MFHI/MFLO in EX
//   i_flush                                    : abort in-flight operation
//   o_hi, o_lo                                 : architectural HI/LO
//   o_busy, o_stall                            : in flight / hold the front of the pipe
//   o_done, o_div_by_zero                      : one-cycle completion pulses
//
// state       | meaning
// MD_ST_IDLE  | waiting for i_start; MTHI/MTLO accepted
// MD_ST_RUN   | 32 add-shift or trial-subtract steps, one per cycle
// MD_ST_FIXUP | apply signs, write HI/LO, pulse o_done
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [1:0]            i_md_op,
  input  logic [DATA_WIDTH-1:0] i_operand_a,
  input  logic [DATA_WIDTH-1:0] i_operand_b,
  input  logic                  i_mthi,
  input  logic                  i_mtlo,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_hilo_read,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic                  o_busy,
  output logic                  o_stall,
  output logic                  o_done,
  output logic                  o_div_by_zero
);

  md_state_e r_state, w_state_nxt;

  logic [MD_CNT_W-1:0]     r_cnt;
  logic [DATA_WIDTH-1:0]   r_acc_hi, r_acc_lo, r_opnd, r_hi, r_lo;
  logic                    r_is_div, r_neg_q, r_neg_r, r_div0, r_done, r_dbz;

  md_op_e                  w_op;
  logic                    w_is_div, w_is_signed, w_sign_a, w_sign_b;
  logic [DATA_WIDTH-1:0]   w_abs_a, w_abs_b, w_step_hi, w_step_lo, w_quo, w_rem;
  logic [2*DATA_WIDTH-1:0] w_prod;

  assign w_op        = md_op_e'(i_md_op);
  assign w_is_div    = (w_op == MD_OP_DIV) || (w_op == MD_OP_DIVU);
  assign w_is_signed = (w_op == MD_OP_MULT) || (w_op == MD_OP_DIV);
  assign w_sign_a    = w_is_signed & i_operand_a[DATA_WIDTH-1];
  assign w_sign_b    = w_is_signed & i_operand_b[DATA_WIDTH-1];
  assign w_abs_a     = md_abs(i_operand_a, w_is_signed);
  assign w_abs_b     = md_abs(i_operand_b, w_is_signed);

  muldiv_ctrl_iter u_iter (
    .i_is_div (r_is_div),
    .i_acc_hi (r_acc_hi),
    .i_acc_lo (r_acc_lo),
    .i_opnd   (r_opnd),
    .o_acc_hi (w_step_hi),
    .o_acc_lo (w_step_lo)
  );

  // With a zero divisor every trial subtract succeeds, so the remainder ends
  // up as |a|; restoring the dividend sign gives back the original operand a.
  // Only the quotient needs forcing to all ones.
  assign w_prod = r_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
  assign w_quo  = r_div0 ? '1 : (r_neg_q ? md_neg(r_acc_lo) : r_acc_lo);
  assign w_rem  = r_neg_r ? md_neg(r_acc_hi) : r_acc_hi;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= MD_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_ST_IDLE:  if (i_start) w_state_nxt = MD_ST_RUN;
      MD_ST_RUN:   if (r_cnt == '0) w_state_nxt = MD_ST_FIXUP;
      MD_ST_FIXUP: w_state_nxt = MD_ST_IDLE;
      default:     w_state_nxt = MD_ST_IDLE;
    endcase
    if (i_flush) w_state_nxt = MD_ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        MD_ST_IDLE: begin
          if (i_mthi) r_hi <= i_wdata;
          if (i_mtlo) r_lo <= i_wdata;
          if (i_start && !i_flush) begin
            r_cnt    <= MD_CNT_LOAD;
            r_is_div <= w_is_div;
            r_neg_q  <= w_sign_a ^ w_sign_b;
            r_neg_r  <= w_sign_a;
            r_div0   <= w_is_div && (i_operand_b == '0);
            r_acc_hi <= '0;
            r_acc_lo <= w_is_div ? w_abs_a : w_abs_b;
            r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
          end
        end
        MD_ST_RUN: begin
          if (!i_flush) begin
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
            r_cnt    <= r_cnt - 1'b1;
          end
        end
        MD_ST_FIXUP: begin
          if (!i_flush) begin
            if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
              r_lo <= w_prod[DATA_WIDTH-1:0];
            end
            r_done <= 1'b1;
            r_dbz  <= r_is_div & r_div0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_busy        = (r_state != MD_ST_IDLE);
  assign o_stall       = o_busy & (i_start | i_hilo_read | i_mthi | i_mtlo);
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;

endmodule
